// File: rtl/switch_input_mmio.sv
// switch_input_mmio -- memory-mapped input peripheral on the CPU data bus.
//
// Brings the board's slide switches and push buttons into the clock domain,
// debounces them, and latches button press events until software clears them.
// Read data is combinational so the single-cycle CPU load path sees it in the
// same cycle the address is presented.
//
// Ports
//   clk    in   1      system clock
//   rst_n  in   1      asynchronous active-low reset
//   addr   in   32     CPU data address
//   re     in   1      CPU load strobe
//   we     in   1      CPU store strobe
//   wdata  in   32     CPU store data (write-1-to-clear for the event register)
//   rdata  out  32     read data, combinational, 0 when not selected
//   hit    out  1      addr matches one of the three registers
//   sw     in   SW_W   raw asynchronous switch inputs
//   btn    in   BTN_W  raw asynchronous button inputs, active-high
//
// Register map
//   SW_ADDR   debounced switch value       (RO)
//   BTN_ADDR  debounced button level       (RO)
//   EVT_ADDR  sticky button press events   (R / W1C)

// Synchroniser + debouncer for one input group. The whole group shares one
// counter: any difference between the synchronised and stable vectors must
// persist, unchanged, for DB_CNT cycles before it is accepted.
module switch_input_mmio_db #(
    parameter int W      = 1,
    parameter int DB_CNT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] pin,
    output logic [W-1:0] stable
);
    localparam int CW = $clog2(DB_CNT);

    logic [W-1:0]  meta;
    logic [W-1:0]  sync;
    logic [CW-1:0] cnt;

    // A change is detected while it is still entering the second sync stage
    // (meta != sync), so the count restarts the cycle before the new value
    // becomes the sync value. A clean edge is accepted 2+DB_CNT cycles after
    // the pin moves; a bounce at any point restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= '0;
            sync   <= '0;
            stable <= '0;
            cnt    <= '0;
        end else begin
            meta <= pin;
            sync <= meta;
            if (sync == stable || meta != sync) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CNT - 1)) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module switch_input_mmio #(
    parameter int          SW_W     = 24,
    parameter int          BTN_W    = 5,
    parameter int          DB_CNT   = 1_000_000,
    parameter logic [31:0] SW_ADDR  = 32'hFFFFF070,
    parameter logic [31:0] BTN_ADDR = 32'hFFFFF074,
    parameter logic [31:0] EVT_ADDR = 32'hFFFFF078
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      addr,
    input  logic             re,
    input  logic             we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             hit,
    input  logic [SW_W-1:0]  sw,
    input  logic [BTN_W-1:0] btn
);
    logic [SW_W-1:0]  sw_stable;
    logic [BTN_W-1:0] btn_stable;
    logic [BTN_W-1:0] btn_stable_d;
    logic [BTN_W-1:0] evt;
    logic [BTN_W-1:0] evt_set;
    logic [BTN_W-1:0] evt_clr;

    logic sel_sw, sel_btn, sel_evt;

    // Only the low BTN_W store bits address event flags.
    logic wdata_unused;
    assign wdata_unused = ^wdata[31:BTN_W];

    switch_input_mmio_db #(.W(SW_W), .DB_CNT(DB_CNT)) u_db_sw (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin    (sw),
        .stable (sw_stable)
    );

    switch_input_mmio_db #(.W(BTN_W), .DB_CNT(DB_CNT)) u_db_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin    (btn),
        .stable (btn_stable)
    );

    assign sel_sw  = (addr == SW_ADDR);
    assign sel_btn = (addr == BTN_ADDR);
    assign sel_evt = (addr == EVT_ADDR);
    assign hit     = sel_sw | sel_btn | sel_evt;

    // Press event = rising edge of the debounced level. Set beats clear so a
    // press landing on the clearing store is never lost.
    assign evt_set = btn_stable & ~btn_stable_d;
    assign evt_clr = (we && sel_evt) ? wdata[BTN_W-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_stable_d <= '0;
            evt          <= '0;
        end else begin
            btn_stable_d <= btn_stable;
            evt          <= (evt & ~evt_clr) | evt_set;
        end
    end

    always_comb begin
        rdata = '0;
        if (re) begin
            if (sel_sw)
                rdata = {{(32-SW_W){1'b0}}, sw_stable};
            else if (sel_btn)
                rdata = {{(32-BTN_W){1'b0}}, btn_stable};
            else if (sel_evt)
                rdata = {{(32-BTN_W){1'b0}}, evt};
        end
    end
endmodule

// File: tb/tb_switch_input_mmio.sv
// Directed bench for switch_input_mmio with a 4-cycle debounce window.
module tb_switch_input_mmio;
    localparam logic [31:0] SW_A  = 32'hFFFFF070;
    localparam logic [31:0] BTN_A = 32'hFFFFF074;
    localparam logic [31:0] EVT_A = 32'hFFFFF078;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        re, we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic [23:0] sw;
    logic [4:0]  btn;

    int vectors = 0;
    int miscompares = 0;

    switch_input_mmio #(.DB_CNT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .re    (re),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .hit   (hit),
        .sw    (sw),
        .btn   (btn)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        re   = 1'b1;
        #1;
        check(tag, rdata, exp);
        re   = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        wdata = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = '0;
        re    = 1'b0;
        we    = 1'b0;
        wdata = '0;
        sw    = 24'hA5A5A5;
        btn   = '0;

        // Reset state
        tick();
        #1;
        check("rst_idle_rdata", rdata, 32'h0);
        check("rst_idle_hit", {31'b0, hit}, 32'h0);
        chk_rd("rst_sw", SW_A, 32'h0);
        chk_rd("rst_evt", EVT_A, 32'h0);
        tick();

        // 1: switch value appears 2 sync + 4 debounce cycles after release
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk_rd($sformatf("sw_deb_c%0d", c), SW_A, (c >= 6) ? 32'h00A5A5A5 : 32'h0);
        end

        // 2: bouncing btn[0] never becomes stable
        for (int i = 0; i < 10; i++) begin
            btn[0] = 1'b1;
            tick();
            tick();
            btn[0] = 1'b0;
            tick();
            tick();
        end
        repeat (8) tick();
        chk_rd("bounce_btn", BTN_A, 32'h0);
        chk_rd("bounce_evt", EVT_A, 32'h0);

        // 3: clean btn[2] press; level after 6 cycles, event one cycle later
        btn[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk_rd($sformatf("press_btn_k%0d", k), BTN_A, (k >= 6) ? 32'h4 : 32'h0);
            chk_rd($sformatf("press_evt_k%0d", k), EVT_A, (k >= 7) ? 32'h4 : 32'h0);
        end
        btn[2] = 1'b0;
        repeat (8) tick();
        chk_rd("release_btn", BTN_A, 32'h0);
        chk_rd("release_evt_sticky", EVT_A, 32'h4);
        chk_rd("release_evt_sticky2", EVT_A, 32'h4);

        // 4: write-1-to-clear, then clear colliding with a new rising edge
        store(EVT_A, 32'h4);
        chk_rd("evt_cleared", EVT_A, 32'h0);
        btn[2] = 1'b1;
        repeat (6) tick();
        chk_rd("collide_btn", BTN_A, 32'h4);
        chk_rd("collide_evt_pre", EVT_A, 32'h0);
        store(EVT_A, 32'h4);
        chk_rd("collide_set_wins", EVT_A, 32'h4);
        btn[2] = 1'b0;
        repeat (8) tick();

        // Two more buttons at once, then a partial clear
        btn = 5'b10010;
        repeat (8) tick();
        chk_rd("multi_btn", BTN_A, 32'h12);
        chk_rd("multi_evt", EVT_A, 32'h16);
        btn = '0;
        repeat (8) tick();
        store(EVT_A, 32'h10);
        chk_rd("partial_clr", EVT_A, 32'h06);

        // 5: decode
        addr = 32'hFFFFF060;
        re   = 1'b1;
        #1;
        check("miss_hit", {31'b0, hit}, 32'h0);
        check("miss_rdata", rdata, 32'h0);
        re   = 1'b0;
        addr = BTN_A;
        #1;
        check("hit_no_re", {31'b0, hit}, 32'h1);
        check("rdata_no_re", rdata, 32'h0);
        store(SW_A, 32'h0);
        store(BTN_A, 32'h1F);
        chk_rd("sw_ro", SW_A, 32'h00A5A5A5);
        chk_rd("evt_after_ro_stores", EVT_A, 32'h06);

        // 6: reset in the middle of a pending switch change
        sw = 24'h5A5A5A;
        repeat (4) tick();
        chk_rd("pending_sw", SW_A, 32'h00A5A5A5);
        rst_n = 1'b0;
        #1;
        chk_rd("midrst_sw", SW_A, 32'h0);
        chk_rd("midrst_evt", EVT_A, 32'h0);
        chk_rd("midrst_btn", BTN_A, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk_rd($sformatf("post_rst_sw_c%0d", c), SW_A, (c >= 6) ? 32'h005A5A5A : 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
